ram_requester: RTL and testbench

//  Initiator (cpu side) of the cpu_ram_if protocol. Arbitrates an instruction-fetch

---
 rtl/ram_requester.sv | 172 +++++++++++++++++
 tb/tb_ram_requester.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_requester.sv
// rtl/ram_requester.sv - instruction/data arbiter onto the single cpu_ram_if RAM port
//
// Purpose: grants one request at a time (data over instruction) and registers its
// op, address and store data. It holds the RAM port stable until ramstate reports
// ACCESS or ERROR. It then pulses the granted port's wait low for one cycle and
// returns the load word. One GAP cycle with the RAM enables low follows every
// transaction.
//
// Ports:
//   CLK, nRST                     clock (rising edge), asynchronous active-low reset
//   halt                          blocks new grants; an in-flight transaction finishes
//   iREN, iaddr -> iload, iwait   instruction read port
//   dREN, dWEN, daddr, dstore     data port (dWEN set = write)
//     -> dload, dwait
//   ramREN, ramWEN, ramaddr,      RAM request, driven only from the capture registers
//     ramstore
//   ramload, ramstate             RAM response (FREE/BUSY/ACCESS/ERROR = 0/1/2/3)
//   err                           sticky: ERROR response or timeout seen
//
// Parameters: BAD_WORD is the load value returned on an aborted transaction.
// TIMEOUT_CYC exists only with the build macro REQ_TIMEOUT_EN. With that macro, a
// request that gets no ACCESS by its TIMEOUT_CYC-th cycle is aborted.
module ram_requester #(
  parameter logic [31:0] BAD_WORD = 32'hBAD1BAD1
`ifdef REQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IREQ, DREQ, GAP} state_t;

  state_t      state_q, state_d;
  logic        ramren_q, ramren_d;
  logic        ramwen_q, ramwen_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;

  logic        in_req, timeout_hit, failed, done, i_done, d_done;
  logic [31:0] done_val;

  assign in_req = (state_q == IREQ) || (state_q == DREQ);

`ifdef REQ_TIMEOUT_EN
  logic [6:0] cnt_q, cnt_d;

  // Counter is zero during the first request cycle, so the abort lands on the
  // TIMEOUT_CYC-th cycle spent waiting.
  assign timeout_hit = in_req && (cnt_q == 7'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)
      cnt_d = '0;
    else if (in_req && !done)
      cnt_d = cnt_q + 7'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // A genuine ACCESS wins over a timeout reached in the same cycle.
  assign failed   = in_req && ((ramstate == RS_ERROR) ||
                               (timeout_hit && (ramstate != RS_ACCESS)));
  assign done     = (in_req && (ramstate == RS_ACCESS)) || failed;
  assign done_val = failed ? BAD_WORD : ramload;
  assign i_done   = done && (state_q == IREQ);
  assign d_done   = done && (state_q == DREQ);

  always_comb begin
    state_d  = state_q;
    ramren_d = ramren_q;
    ramwen_d = ramwen_q;
    err_d    = err_q;
    addr_d   = addr_q;
    store_d  = store_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    case (state_q)
      IDLE: begin
        if (!halt && (dREN || dWEN)) begin
          state_d  = DREQ;
          addr_d   = daddr;
          store_d  = dstore;
          ramren_d = !dWEN;
          ramwen_d = dWEN;
        end else if (!halt && iREN) begin
          state_d  = IREQ;
          addr_d   = iaddr;
          ramren_d = 1'b1;
          ramwen_d = 1'b0;
        end
      end
      IREQ, DREQ: begin
        if (done) begin
          state_d  = GAP;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
          if (failed) err_d = 1'b1;
          if (state_q == IREQ) iload_d = done_val;
          else                 dload_d = done_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ramren_q <= 1'b0;
      ramwen_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      state_q  <= state_d;
      ramren_q <= ramren_d;
      ramwen_q <= ramwen_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
    end
  end

  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign err      = err_q;
  assign iwait    = !i_done;
  assign dwait    = !d_done;
  // The completion cycle already shows the returned word; it is held afterwards.
  assign iload    = i_done ? done_val : iload_q;
  assign dload    = d_done ? done_val : dload_q;

endmodule

// File: tb/tb_ram_requester.sv
// tb/tb_ram_requester.sv - self-checking bench for ram_requester with a LAT=2 RAM model
module tb_ram_requester;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam int LAT = 2;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK, nRST, halt;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, iload, dload;
  logic        iwait, dwait;
  logic        ramREN, ramWEN, err;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int total = 0;
  int bad   = 0;

  ram_requester dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5000000 | (32'(i) * 32'h00010203);
  endfunction

  // ---------------- RAM model: request must stay stable LAT+1 edges ----------------
  logic [31:0] ram_mem [0:255];
  bit          mem_loaded = 1'b0;
  logic [1:0]  rs;
  logic [31:0] rload;
  int          mcnt, restarts;
  bit          mdone, force_busy, force_err;
  logic [65:0] sig, last_sig;

  assign sig      = {ramREN, ramWEN, ramaddr, ramstore};
  assign ramstate = rs;
  assign ramload  = rload;

  always @(posedge CLK or negedge nRST) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
      ram_mem[16] = 32'hCAFEF00D;
      mem_loaded = 1'b1;
    end
    if (!nRST) begin
      rs <= FREE; mcnt <= 0; mdone <= 1'b0; last_sig <= '0; rload <= '0; restarts <= 0;
    end else begin
      last_sig <= sig;
      if (!(ramREN || ramWEN)) begin
        rs <= FREE; mcnt <= 0; mdone <= 1'b0;
      end else if (force_busy) begin
        rs <= BUSY;
      end else if (force_err) begin
        rs <= ERROR;
      end else if (mdone) begin
        rs <= FREE;
      end else if ((last_sig[65] || last_sig[64]) && sig != last_sig) begin
        restarts <= restarts + 1; mcnt <= 1; rs <= BUSY;
      end else if (mcnt == LAT) begin
        rs <= ACCESS; mdone <= 1'b1;
        if (ramWEN) ram_mem[ramaddr[9:2]] = ramstore;
        else        rload <= ram_mem[ramaddr[9:2]];
      end else begin
        mcnt <= mcnt + 1; rs <= BUSY;
      end
    end
  end

  // ---------------- reference memory and checkers ----------------
  logic [31:0] exp_mem [0:255];

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for the selected port's wait to drop; checks the other port stays waiting
  // and that the drop comes exactly exp_c negedges after the call.
  task automatic wait_done(input bit is_d, input int exp_c, input string tag);
    int c;
    bit seen, other_ok;
    c = 0; seen = 1'b0; other_ok = 1'b1;
    while (!seen && c < 200) begin
      @(negedge CLK);
      c++;
      if ((is_d ? iwait : dwait) !== 1'b1) other_ok = 1'b0;
      if ((is_d ? dwait : iwait) === 1'b0) seen = 1'b1;
    end
    chk1({tag, " other_wait_high"}, other_ok, 1'b1);
    chk32({tag, " latency"}, 32'(c), 32'(exp_c));
  endtask

  task automatic clear_req();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  // One complete transaction from IDLE; leaves the DUT back in IDLE.
  task automatic txn(input bit is_d, input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] expv;
    clear_req();
    if (is_d) begin
      daddr = a; dstore = d;
      if (wr) begin dWEN = 1'b1; dREN = 1'($urandom_range(0, 1)); end
      else    dREN = 1'b1;
    end else begin
      iREN = 1'b1; iaddr = a;
    end
    if (wr) exp_mem[a[9:2]] = d;
    expv = exp_mem[a[9:2]];
    @(negedge CLK);
    chk1("txn ramREN", ramREN, !wr);
    chk1("txn ramWEN", ramWEN, wr);
    chk32("txn ramaddr", ramaddr, a);
    if (wr) chk32("txn ramstore", ramstore, d);
    chk1("txn wait_c1", is_d ? dwait : iwait, 1'b1);
    wait_done(is_d, 3, "txn");
    if (!wr) chk32("txn load", is_d ? dload : iload, expv);
    clear_req();
    @(negedge CLK);
    chk1("gap enables low", ramREN | ramWEN, 1'b0);
    chk1("gap wait high", is_d ? dwait : iwait, 1'b1);
    if (!wr) chk32("load held", is_d ? dload : iload, expv);
    @(negedge CLK);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    exp_mem[16] = 32'hCAFEF00D;
    force_busy = 1'b0; force_err = 1'b0;
    nRST = 1'b0; halt = 1'b0; clear_req();
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(negedge CLK);

    // reset values
    chk1("rst ramREN", ramREN, 1'b0);
    chk1("rst ramWEN", ramWEN, 1'b0);
    chk32("rst ramaddr", ramaddr, 32'h0);
    chk32("rst ramstore", ramstore, 32'h0);
    chk1("rst err", err, 1'b0);
    chk1("rst iwait", iwait, 1'b1);
    chk1("rst dwait", dwait, 1'b1);
    chk32("rst iload", iload, 32'h0);
    chk32("rst dload", dload, 32'h0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // directed data read of 0x40
    txn(1'b1, 1'b0, 32'h40, 32'h0);
    chk32("read 0x40 value", dload, 32'hCAFEF00D);

    // simultaneous instruction read and data write: data first, then instruction
    iREN = 1'b1; iaddr = 32'h80;
    dWEN = 1'b1; dREN = 1'b0; daddr = 32'h80; dstore = 32'h12345678;
    exp_mem[32] = 32'h12345678;
    @(negedge CLK);
    chk1("simul ramWEN", ramWEN, 1'b1);
    chk1("simul ramREN", ramREN, 1'b0);
    wait_done(1'b1, 3, "simul write");
    dWEN = 1'b0;
    wait_done(1'b0, 6, "simul ifetch");
    chk32("simul iload", iload, 32'h12345678);
    clear_req();
    repeat (2) @(negedge CLK);
    txn(1'b1, 1'b0, 32'h80, 32'h0);

    // address changed and request dropped mid-transaction
    dREN = 1'b1; daddr = 32'hC0;
    @(negedge CLK);
    daddr = 32'h44;
    @(negedge CLK);
    chk32("hold ramaddr", ramaddr, 32'hC0);
    dREN = 1'b0;
    wait_done(1'b1, 2, "hold");
    chk32("hold ramaddr at done", ramaddr, 32'hC0);
    chk32("hold dload", dload, exp_mem[48]);
    chk32("hold ram restarts", 32'(restarts), 32'd0);
    repeat (2) @(negedge CLK);

    // halt blocks new grants but not an in-flight read
    halt = 1'b1; iREN = 1'b1; iaddr = 32'h48;
    ok = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      if (ramREN !== 1'b0 || iwait !== 1'b1) ok = 1'b0;
    end
    chk1("halt no grant", ok, 1'b1);
    halt = 1'b0;
    @(negedge CLK);
    chk1("halt release grant", ramREN, 1'b1);
    halt = 1'b1;
    wait_done(1'b0, 3, "halt inflight");
    chk32("halt iload", iload, exp_mem[18]);
    clear_req(); halt = 1'b0;
    repeat (2) @(negedge CLK);

    // randomized traffic against the reference memory
    for (int n = 0; n < 30; n++) begin
      bit is_d, wr;
      logic [31:0] a, d;
      is_d = 1'($urandom_range(0, 1));
      wr   = is_d && ($urandom_range(0, 2) == 0);
      a    = 32'h100 + 32'(4 * $urandom_range(0, 15));
      d    = $urandom;
      txn(is_d, wr, a, d);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    // ERROR response: completes with BAD word and sets err
    force_err = 1'b1;
    dREN = 1'b1; daddr = 32'h50;
    wait_done(1'b1, 2, "error");
    chk32("error dload", dload, BAD);
    clear_req();
    @(negedge CLK);
    chk1("error err sticky", err, 1'b1);
    force_err = 1'b0;
    repeat (2) @(negedge CLK);
    chk1("error err still set", err, 1'b1);

    // RAM stuck BUSY
    force_busy = 1'b1;
    dREN = 1'b1; daddr = 32'h60;
`ifdef REQ_TIMEOUT_EN
    wait_done(1'b1, 64, "timeout");
    chk32("timeout dload", dload, BAD);
    dREN = 1'b0;
    @(negedge CLK);
    chk1("timeout err", err, 1'b1);
    @(negedge CLK);
    dREN = 1'b1;
    repeat (3) @(negedge CLK);
`else
    ok = 1'b1;
    repeat (100) begin
      @(negedge CLK);
      if (dwait !== 1'b1) ok = 1'b0;
    end
    chk1("busy dwait stays high", ok, 1'b1);
`endif
    chk1("busy in DREQ", ramREN, 1'b1);

    // asynchronous reset mid-transaction
    #1 nRST = 1'b0;
    #1;
    chk1("areset ramREN", ramREN, 1'b0);
    chk32("areset ramaddr", ramaddr, 32'h0);
    chk1("areset err", err, 1'b0);
    chk1("areset dwait", dwait, 1'b1);
    chk32("areset dload", dload, 32'h0);
    chk32("areset iload", iload, 32'h0);
    clear_req(); force_busy = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk1("post reset idle", ramREN | ramWEN, 1'b0);
    txn(1'b1, 1'b0, 32'h40, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
